mem_request_responder: RTL and testbench

- Memory-side responder for the request unit's handshake.
- Accepts imemREN, dmemREN and dmemWEN plus addresses and store data from the request unit and datapath.
- Arbitrates them onto one single-ported RAM port and returns ihit/dhit pulses with load data.
- Sits between the request unit/datapath and the RAM model; it is the other end of the request unit protocol.

---
 rtl/mem_request_responder.sv | 154 +++++++++++++++
 tb/tb_mem_request_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_responder.sv
// Memory-side responder: arbitrates instruction and data requests onto one RAM port and returns ihit/dhit.
// Optional MEMRESP_PERF_EN adds icount/dcount completion counters.
module mem_request_responder #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int MIN_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] imemload,
  output logic [WORD_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
`ifdef MEMRESP_PERF_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);

  // Handshake: requests are levels held until their hit; ihit/dhit are
  // single-cycle pulses; ramready only counts once the wait counter is full.
  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;

  localparam logic [3:0] LAT = 4'(MIN_LAT);

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic              last_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_store;
  logic              lat_wr;
  logic              d_req;
  logic              pick_d;
  logic              pick_i;
  logic              honoured;

  assign d_req    = dmemREN | dmemWEN;
  // Data wins a tie unless the previous completion was data.
  assign pick_d   = d_req && !(imemREN && last_d);
  assign pick_i   = imemREN && !pick_d;
  assign honoured = (wait_cnt == LAT) && ramready;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_d)      state_next = DACC;
        else if (pick_i) state_next = IACC;
      end
      DACC:    if (honoured) state_next = DRESP;
      IACC:    if (honoured) state_next = IRESP;
      DRESP:   state_next = IDLE;
      IRESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    case (state)
      DACC: begin
        ramWEN   = lat_wr;
        ramREN   = !lat_wr;
        ramaddr  = lat_addr;
        ramstore = lat_store;
      end
      IACC: begin
        ramREN   = 1'b1;
        ramaddr  = lat_addr;
        ramstore = lat_store;
      end
      DRESP:   dhit = 1'b1;
      IRESP:   ihit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt  <= '0;
      last_d    <= 1'b0;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wr    <= 1'b0;
      imemload  <= '0;
      dmemload  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (pick_d) begin
            lat_addr  <= dmemaddr;
            lat_store <= dmemstore;
            lat_wr    <= dmemWEN;
          end else if (pick_i) begin
            lat_addr  <= imemaddr;
            lat_store <= '0;
            lat_wr    <= 1'b0;
          end
        end
        DACC, IACC: begin
          if (wait_cnt != LAT) wait_cnt <= wait_cnt + 4'd1;
          if (honoured) begin
            if (state == DACC) begin
              last_d <= 1'b1;
              if (!lat_wr) dmemload <= ramload;
            end else begin
              last_d   <= 1'b0;
              imemload <= ramload;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMRESP_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (ihit) icount <= icount + 32'd1;
      if (dhit) dcount <= dcount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_responder.sv
// Self-checking bench for mem_request_responder: transaction-level model checked every cycle plus directed vectors.
module tb_mem_request_responder;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int MIN_LAT = 1;
  localparam int KD = 1;
  localparam int KI = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          imemREN, dmemREN, dmemWEN, ramready;
  logic [AW-1:0] imemaddr, dmemaddr;
  logic [WW-1:0] dmemstore, ramload;
  logic          ihit, dhit, ramREN, ramWEN;
  logic [WW-1:0] imemload, dmemload, ramstore;
  logic [AW-1:0] ramaddr;
`ifdef MEMRESP_PERF_EN
  logic [31:0]   icount, dcount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_request_responder #(.ADDR_W(AW), .WORD_W(WW), .MIN_LAT(MIN_LAT)) dut (
    .CLK(clk), .RST(rst),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
`ifdef MEMRESP_PERF_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: which transaction is in flight, how long it has waited, and whether
  // this is its response cycle.
  bit          m_on = 1'b0;
  int          m_kind = 0;
  bit          m_resp = 1'b0;
  int          m_age = 0;
  logic [31:0] m_addr = '0, m_data = '0;
  bit          m_wr = 1'b0;
  bit          m_last_d = 1'b0;
  logic [31:0] m_iload = '0, m_dload = '0, m_icnt = '0, m_dcnt = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on <= 1'b1; m_kind <= 0; m_resp <= 1'b0; m_age <= 0; m_last_d <= 1'b0;
      m_iload <= '0; m_dload <= '0; m_icnt <= '0; m_dcnt <= '0;
    end else if (m_resp) begin
      m_kind <= 0;
      m_resp <= 1'b0;
      if (m_kind == KD) m_dcnt <= m_dcnt + 1;
      else              m_icnt <= m_icnt + 1;
    end else if (m_kind == 0) begin
      if ((dmemREN || dmemWEN) && !(imemREN && m_last_d)) begin
        m_kind <= KD; m_addr <= dmemaddr; m_data <= dmemstore; m_wr <= dmemWEN; m_age <= 0;
      end else if (imemREN) begin
        m_kind <= KI; m_addr <= imemaddr; m_data <= '0; m_wr <= 1'b0; m_age <= 0;
      end
    end else begin
      if (m_age >= MIN_LAT && ramready) begin
        m_resp <= 1'b1;
        if (m_kind == KD) begin
          m_last_d <= 1'b1;
          if (!m_wr) m_dload <= ramload;
        end else begin
          m_last_d <= 1'b0;
          m_iload  <= ramload;
        end
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      automatic bit acc = (m_kind != 0) && !m_resp;
      check("m_ramREN",   ramREN,   acc && (m_kind == KI || !m_wr));
      check("m_ramWEN",   ramWEN,   acc && m_kind == KD && m_wr);
      check("m_ramaddr",  ramaddr,  acc ? m_addr : 32'h0);
      check("m_ramstore", ramstore, (acc && m_kind == KD) ? m_data : 32'h0);
      check("m_ihit",     ihit,     m_resp && m_kind == KI);
      check("m_dhit",     dhit,     m_resp && m_kind == KD);
      check("m_imemload", imemload, m_iload);
      check("m_dmemload", dmemload, m_dload);
`ifdef MEMRESP_PERF_EN
      check("m_icount",   icount,   m_icnt);
      check("m_dcount",   dcount,   m_dcnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef MEMRESP_PERF_EN
  task automatic do_access(input bit is_d, input logic [31:0] addr);
    int n = 0;
    if (is_d) begin dmemREN = 1'b1; dmemaddr = addr; end
    else      begin imemREN = 1'b1; imemaddr = addr; end
    step();
    while (!(is_d ? dhit : ihit) && n < 20) begin step(); n++; end
    if (n >= 20) check("perf_hit_timeout", 1'b0, 1'b1);
    dmemREN = 1'b0; imemREN = 1'b0;
    step();
  endtask
`endif

  logic [7:0] hit_kind[$];
  int         hit_cyc[$];

  initial begin
    rst = 1'b1; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; ramready = 1'b0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0;
    step(); step();
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_dmemload", dmemload, 32'h0);

    // Single data read, released with reset at cycle 0
    rst = 1'b0; ramready = 1'b1; ramload = 32'hDEADBEEF; dmemREN = 1'b1; dmemaddr = 32'h100;
    step();
    check("rd_c1_ren", ramREN, 1'b1); check("rd_c1_addr", ramaddr, 32'h100); check("rd_c1_dhit", dhit, 1'b0);
    step();
    check("rd_c2_ren", ramREN, 1'b1); check("rd_c2_dhit", dhit, 1'b0);
    step();
    check("rd_c3_dhit", dhit, 1'b1); check("rd_c3_ren", ramREN, 1'b0);
    check("rd_c3_addr", ramaddr, 32'h0); check("rd_load", dmemload, 32'hDEADBEEF);
    dmemREN = 1'b0;
    step();
    check("rd_c4_dhit", dhit, 1'b0);

    // Data write: load must not move even though ramload differs
    dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'h12345678; ramload = 32'h55555555;
    step();
    check("wr_c1_wen", ramWEN, 1'b1); check("wr_c1_ren", ramREN, 1'b0);
    check("wr_c1_store", ramstore, 32'h12345678); check("wr_c1_addr", ramaddr, 32'h40);
    step();
    check("wr_c2_dhit", dhit, 1'b0);
    step();
    check("wr_c3_dhit", dhit, 1'b1); check("wr_load_hold", dmemload, 32'hDEADBEEF);
    dmemWEN = 1'b0;
    step();
    check("wr_c4_dhit", dhit, 1'b0);

    // REN and WEN together act as a write
    dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h44; dmemstore = 32'hA5A5A5A5; ramload = 32'h11111111;
    step();
    check("rw_wen", ramWEN, 1'b1); check("rw_ren", ramREN, 1'b0); check("rw_store", ramstore, 32'hA5A5A5A5);
    step(); step();
    check("rw_dhit", dhit, 1'b1); check("rw_load_hold", dmemload, 32'hDEADBEEF);
    dmemREN = 1'b0; dmemWEN = 1'b0;
    step();

    // Contention from reset: D, I, D, I
    rst = 1'b1; step();
    rst = 1'b0; imemREN = 1'b1; dmemREN = 1'b1; imemaddr = 32'h8; dmemaddr = 32'h200;
    ramready = 1'b1; ramload = 32'h77;
    for (int c = 1; c <= 16; c++) begin
      step();
      check("ct_not_both", ihit & dhit, 1'b0);
      if (dhit) begin hit_kind.push_back("D"); hit_cyc.push_back(c); end
      if (ihit) begin hit_kind.push_back("I"); hit_cyc.push_back(c); end
    end
    imemREN = 1'b0; dmemREN = 1'b0;
    check("ct_count", hit_kind.size(), 4);
    if (hit_kind.size() == 4) begin
      check("ct_k0", hit_kind[0], "D"); check("ct_t0", hit_cyc[0], 3);
      check("ct_k1", hit_kind[1], "I"); check("ct_t1", hit_cyc[1], 7);
      check("ct_k2", hit_kind[2], "D"); check("ct_t2", hit_cyc[2], 11);
      check("ct_k3", hit_kind[3], "I"); check("ct_t3", hit_cyc[3], 15);
    end
    step();

    // RAM stall on an instruction fetch
    imemREN = 1'b1; imemaddr = 32'h4; ramready = 1'b0; ramload = 32'hCAFE0004;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("st_ren", ramREN, 1'b1); check("st_addr", ramaddr, 32'h4); check("st_ihit", ihit, 1'b0);
    end
    step();
    ramready = 1'b1;
    check("st_c6_ihit", ihit, 1'b0);
    step();
    check("st_c7_ihit", ihit, 1'b1); check("st_load", imemload, 32'hCAFE0004);
    imemREN = 1'b0;
    step();
    check("st_c8_ihit", ihit, 1'b0);

    // Reset in the middle of a data access
    dmemREN = 1'b1; dmemaddr = 32'h200; ramready = 1'b0; ramload = 32'h99;
    step();
    check("ra_ren", ramREN, 1'b1);
    rst = 1'b1; dmemREN = 1'b0;
    step();
    check("ra_ren0", ramREN, 1'b0); check("ra_addr0", ramaddr, 32'h0); check("ra_dhit", dhit, 1'b0);
    check("ra_dload", dmemload, 32'h0); check("ra_iload", imemload, 32'h0);
    rst = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h300; ramready = 1'b1; ramload = 32'h0BADF00D;
    step();
    check("ra_n_dhit1", dhit, 1'b0); check("ra_n_addr", ramaddr, 32'h300);
    step();
    check("ra_n_dhit2", dhit, 1'b0);
    step();
    check("ra_n_dhit3", dhit, 1'b1); check("ra_n_load", dmemload, 32'h0BADF00D);
    dmemREN = 1'b0;
    step();

`ifdef MEMRESP_PERF_EN
    rst = 1'b1; step(); rst = 1'b0;
    ramready = 1'b1; ramload = 32'h1234;
    do_access(1'b1, 32'h10); do_access(1'b1, 32'h14); do_access(1'b1, 32'h18);
    do_access(1'b0, 32'h20); do_access(1'b0, 32'h24);
    check("pf_dcount", dcount, 32'd3); check("pf_icount", icount, 32'd2);
    rst = 1'b1; step();
    check("pf_dcount_rst", dcount, 32'd0); check("pf_icount_rst", icount, 32'd0);
    rst = 1'b0; step();
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
